// File: rtl/demod_multigate.sv
// Multi-gate quadrature demodulator: mixes each receive line against an N-phase sin/cos table
// locked to line start and emits one saturating I/Q sum per range gate over valid/ready.
module demod_multigate #(
  parameter int ADC_W  = 14,
  parameter int LUT_W  = 8,
  parameter int ACC_W  = 32,
  parameter int PHASES = 8,
  parameter int NGATE  = 4
) (
  input  logic             DEMODCLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic [ADC_W-1:0] adcValue,
  input  logic [15:0]      GATE_DELAY,
  input  logic [7:0]       SV_LEN,
  output logic [ACC_W-1:0] OUT_I,
  output logic [ACC_W-1:0] OUT_Q,
  output logic [7:0]       OUT_GATE,
  output logic             OUT_SAT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             OVERRUN
);
  // state | meaning
  // IDLE  | waiting for ENABLE; the first enabled edge is sample n=0
  // DELAY | counting range-delay samples before gate 0
  // ACCUM | tagging samples into gates 0..NGATE-1
  // DONE  | all gates issued, waiting for ENABLE to drop
  typedef enum logic [1:0] {IDLE, DELAY, ACCUM, DONE} state_t;

  localparam int  PW  = $clog2(PHASES);
  localparam int  PRW = ADC_W + LUT_W;
  localparam int  AMP = 2 ** (LUT_W - 1) - 1;
  localparam real PI  = 3.14159265358979323846;
  localparam logic signed [ACC_W:0] SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SUM_MIN = {2'b11, {(ACC_W-2){1'b0}}, 1'b1};

  logic signed [LUT_W-1:0] cos_lut [PHASES];
  logic signed [LUT_W-1:0] sin_lut [PHASES];

  for (genvar p = 0; p < PHASES; p++) begin : g_lut
    localparam real C  = AMP * $cos(2.0 * PI * p / PHASES);
    localparam real S  = AMP * $sin(2.0 * PI * p / PHASES);
    localparam int  CI = (C >= 0.0) ? $rtoi(C + 0.5) : -$rtoi(-C + 0.5);
    localparam int  SI = (S >= 0.0) ? $rtoi(S + 0.5) : -$rtoi(-S + 0.5);
    assign cos_lut[p] = LUT_W'(CI);
    assign sin_lut[p] = LUT_W'(SI);
  end

  state_t          state_q, state_d;
  logic [15:0]     dly_q, dly_d;
  logic [7:0]      len_q, len_d, rem_q, rem_d, gate_q, gate_d;
  logic [PW-1:0]   phase_q, phase_d;

  logic            line_start, enter_gate, gate_smp, smp_first, smp_last, last_gate;
  logic [7:0]      eff_len, cur_rem, cur_gate;
  logic [PW-1:0]   smp_phase;

  assign line_start = (state_q == IDLE) && ENABLE;
  assign eff_len    = line_start ? SV_LEN : len_q;
  assign enter_gate = (line_start && GATE_DELAY == 16'd0 && SV_LEN != 8'd0) ||
                      (state_q == DELAY && ENABLE && dly_q == 16'd0 && len_q != 8'd0);
  assign gate_smp   = enter_gate || (state_q == ACCUM && ENABLE);
  assign cur_rem    = enter_gate ? eff_len : rem_q;
  assign cur_gate   = enter_gate ? 8'd0 : gate_q;
  assign smp_first  = (cur_rem == eff_len);
  assign smp_last   = (cur_rem == 8'd1);
  assign last_gate  = (cur_gate == 8'(NGATE - 1));
  assign smp_phase  = line_start ? '0 : phase_q;

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    len_d   = len_q;
    rem_d   = rem_q;
    gate_d  = gate_q;
    phase_d = phase_q + PW'(1);
    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (ENABLE) begin
          phase_d = PW'(1);
          len_d   = SV_LEN;
          if (GATE_DELAY != 16'd0) begin
            state_d = DELAY;
            dly_d   = GATE_DELAY - 16'd1;
          end else if (SV_LEN == 8'd0) begin
            state_d = DONE;
          end
        end
      end
      DELAY: begin
        if (!ENABLE)               state_d = IDLE;
        else if (dly_q != 16'd0)   dly_d   = dly_q - 16'd1;
        else if (len_q == 8'd0)    state_d = DONE;
      end
      ACCUM:   if (!ENABLE) state_d = IDLE;
      DONE:    if (!ENABLE) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Gate bookkeeping is shared by the entry edge and the ACCUM edges.
    if (gate_smp) begin
      state_d = ACCUM;
      if (!smp_last) begin
        rem_d  = cur_rem - 8'd1;
        gate_d = cur_gate;
      end else if (last_gate) begin
        state_d = DONE;
      end else begin
        rem_d  = eff_len;
        gate_d = cur_gate + 8'd1;
      end
    end
  end

  always_ff @(posedge DEMODCLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      dly_q   <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      gate_q  <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      gate_q  <= gate_d;
      phase_q <= phase_d;
    end
  end

  logic [ADC_W-1:0]  s1_adc;
  logic [PW-1:0]     s1_phase;
  logic              s1_vld, s1_first, s1_last, s2_vld, s2_first, s2_last;
  logic [7:0]        s1_gate, s2_gate;
  logic [ACC_W-1:0]  p_i, p_q, acc_i, acc_q;
  logic              sat_i, sat_q;
  logic signed [PRW-1:0] prod_i, prod_q;
  logic [ACC_W:0]    r_i, r_q;
  logic              load;

  assign prod_i = $signed(s1_adc) * cos_lut[s1_phase];
  assign prod_q = $signed(s1_adc) * sin_lut[s1_phase];

  // Returns {saturated, value}; a held channel keeps its clamp value for the rest of the gate.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] base,
                                             input logic [ACC_W-1:0] p, input logic held);
    logic signed [ACC_W:0] s;
    s = $signed({base[ACC_W-1], base}) + $signed({p[ACC_W-1], p});
    if (held)             sat_add = {1'b1, base};
    else if (s > SUM_MAX) sat_add = {1'b1, SUM_MAX[ACC_W-1:0]};
    else if (s < SUM_MIN) sat_add = {1'b1, SUM_MIN[ACC_W-1:0]};
    else                  sat_add = {1'b0, s[ACC_W-1:0]};
  endfunction

  assign r_i  = sat_add(s2_first ? '0 : acc_i, p_i, !s2_first && sat_i);
  assign r_q  = sat_add(s2_first ? '0 : acc_q, p_q, !s2_first && sat_q);
  assign load = s2_vld && s2_last;

  always_ff @(posedge DEMODCLK or posedge RESET) begin
    if (RESET) begin
      s1_adc <= '0; s1_phase <= '0; s1_vld <= 1'b0; s1_first <= 1'b0; s1_last <= 1'b0;
      s1_gate <= '0;
      p_i <= '0; p_q <= '0; s2_vld <= 1'b0; s2_first <= 1'b0; s2_last <= 1'b0; s2_gate <= '0;
      acc_i <= '0; acc_q <= '0; sat_i <= 1'b0; sat_q <= 1'b0;
      OUT_I <= '0; OUT_Q <= '0; OUT_GATE <= '0; OUT_SAT <= 1'b0;
      OUT_VALID <= 1'b0; OVERRUN <= 1'b0;
    end else begin
      s1_adc   <= adcValue;
      s1_phase <= smp_phase;
      s1_vld   <= gate_smp;
      s1_first <= smp_first;
      s1_last  <= smp_last;
      s1_gate  <= cur_gate;
      p_i      <= ACC_W'(prod_i);
      p_q      <= ACC_W'(prod_q);
      s2_vld   <= s1_vld;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_gate  <= s1_gate;
      if (s2_vld) begin
        acc_i <= r_i[ACC_W-1:0];
        acc_q <= r_q[ACC_W-1:0];
        sat_i <= r_i[ACC_W];
        sat_q <= r_q[ACC_W];
      end
      if (load) begin
        OUT_I     <= r_i[ACC_W-1:0];
        OUT_Q     <= r_q[ACC_W-1:0];
        OUT_GATE  <= s2_gate;
        OUT_SAT   <= r_i[ACC_W] | r_q[ACC_W];
        OUT_VALID <= 1'b1;
      end else if (OUT_VALID && OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
      if (load && OUT_VALID && !OUT_READY) OVERRUN <= 1'b1;
      else if (line_start)                 OVERRUN <= 1'b0;
    end
  end
endmodule

// File: tb/tb_demod_multigate.sv
// Scoreboard bench for demod_multigate: default instance plus a 22-bit-accumulator
// instance (saturation) and a single-gate instance.
module tb_demod_multigate;
  logic        clk = 1'b0;
  logic        rst;
  logic        line_en;
  int          sel;
  logic [13:0] adc;
  logic [15:0] gate_delay;
  logic [7:0]  sv_len;
  logic        rdy0;
  logic        en0, en1, en2;

  logic              vld [3];
  logic              ovr [3];
  logic              osat [3];
  logic [7:0]        og [3];
  logic signed [31:0] oi [3];
  logic signed [31:0] oq [3];
  logic [31:0]       i0, q0, i2, q2;
  logic [21:0]       i1, q1;

  typedef struct {int inst; int gate; longint i; longint q; bit sat;} exp_t;
  exp_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign en0 = line_en && sel == 0;
  assign en1 = line_en && sel == 1;
  assign en2 = line_en && sel == 2;
  assign oi[0] = i0;  assign oq[0] = q0;
  assign oi[1] = {{10{i1[21]}}, i1};  assign oq[1] = {{10{q1[21]}}, q1};
  assign oi[2] = i2;  assign oq[2] = q2;

  demod_multigate u0 (
    .DEMODCLK(clk), .RESET(rst), .ENABLE(en0), .adcValue(adc), .GATE_DELAY(gate_delay),
    .SV_LEN(sv_len), .OUT_I(i0), .OUT_Q(q0), .OUT_GATE(og[0]), .OUT_SAT(osat[0]),
    .OUT_VALID(vld[0]), .OUT_READY(rdy0), .OVERRUN(ovr[0]));

  demod_multigate #(.ACC_W(22), .NGATE(2)) u1 (
    .DEMODCLK(clk), .RESET(rst), .ENABLE(en1), .adcValue(adc), .GATE_DELAY(gate_delay),
    .SV_LEN(sv_len), .OUT_I(i1), .OUT_Q(q1), .OUT_GATE(og[1]), .OUT_SAT(osat[1]),
    .OUT_VALID(vld[1]), .OUT_READY(1'b1), .OVERRUN(ovr[1]));

  demod_multigate #(.NGATE(1)) u2 (
    .DEMODCLK(clk), .RESET(rst), .ENABLE(en2), .adcValue(adc), .GATE_DELAY(gate_delay),
    .SV_LEN(sv_len), .OUT_I(i2), .OUT_Q(q2), .OUT_GATE(og[2]), .OUT_SAT(osat[2]),
    .OUT_VALID(vld[2]), .OUT_READY(1'b1), .OVERRUN(ovr[2]));

  function automatic void push(int inst, int g, longint i, longint q, bit s);
    exp_t e;
    e.inst = inst; e.gate = g; e.i = i; e.q = q; e.sat = s;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic en, input int a);
    line_en = en;
    adc = 14'(a);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int k);
    repeat (k) step(1'b0, 0);
  endtask

  // Monitor: every negedge where a result will transfer on the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (vld[k] && (k != 0 || rdy0)) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL result inst%0d: unexpected gate=%0d i=%0d q=%0d", k, og[k], oi[k], oq[k]);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.inst != k || e.gate != int'(og[k]) || e.i != longint'(oi[k]) ||
                e.q != longint'(oq[k]) || e.sat != osat[k]) begin
              n_errors++;
              $display("FAIL result inst%0d: got gate=%0d i=%0d q=%0d sat=%0d expected inst%0d gate=%0d i=%0d q=%0d sat=%0d",
                       k, og[k], oi[k], oq[k], osat[k], e.inst, e.gate, e.i, e.q, e.sat);
            end
          end
        end
      end
    end
  end

  initial begin
    int seen;
    rst = 1'b1; line_en = 1'b0; sel = 0; adc = '0;
    gate_delay = 16'd0; sv_len = 8'd8; rdy0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", vld[0], 0);
    chk("reset_i", oi[0], 0);
    chk("reset_overrun", ovr[0], 0);
    rst = 1'b0;
    idle(2);

    // Single tone, latency of first result
    for (int g = 0; g < 4; g++) push(0, g, 12700, 0, 0);
    for (int n = 0; n < 32; n++) begin
      step(1'b1, (n % 8 == 0) ? 100 : 0);
      if (n == 8) chk("latency_edge8_valid", vld[0], 0);
      if (n == 9) chk("latency_edge9_valid", vld[0], 1);
    end
    idle(6);

    // DC rejection with delay 3
    gate_delay = 16'd3;
    for (int g = 0; g < 4; g++) push(0, g, 0, 0, 0);
    for (int n = 0; n < 35; n++) step(1'b1, 1000);
    idle(6);

    // Phase lock: tone at phase 2 with delay 2
    gate_delay = 16'd2;
    for (int g = 0; g < 4; g++) push(0, g, 0, 12700, 0);
    for (int n = 0; n < 34; n++) step(1'b1, (n % 8 == 2) ? 100 : 0);
    idle(6);

    // Back-pressure with overwrite
    gate_delay = 16'd0; sv_len = 8'd2; rdy0 = 1'b0;
    for (int n = 0; n < 8; n++) begin
      step(1'b1, n + 1);
      if (n == 3) begin
        chk("bp_g0_gate", og[0], 0);
        chk("bp_g0_i", oi[0], 307);
        chk("bp_g0_overrun", ovr[0], 0);
      end
      if (n == 4) chk("bp_frozen_i", oi[0], 307);
      if (n == 5) begin
        chk("bp_g1_gate", og[0], 1);
        chk("bp_g1_overrun", ovr[0], 1);
      end
      if (n == 7) begin
        chk("bp_g2_gate", og[0], 2);
        chk("bp_g2_i", oi[0], -1175);
        rdy0 = 1'b1;
        push(0, 2, -1175, -540, 0);
        push(0, 3, 720, -1609, 0);
      end
    end
    idle(5);
    chk("bp_overrun_sticky", ovr[0], 1);

    // Ready pulsed exactly on a load edge
    rdy0 = 1'b0;
    for (int n = 0; n < 8; n++) begin
      step(1'b1, n + 1);
      if (n == 4) begin
        rdy0 = 1'b1;
        push(0, 0, 307, 180, 0);
      end
      if (n == 5) begin
        rdy0 = 1'b0;
        chk("pulse_overrun", ovr[0], 0);
        chk("pulse_valid", vld[0], 1);
        chk("pulse_gate", og[0], 1);
      end
      if (n == 6) begin
        rdy0 = 1'b1;
        push(0, 1, -360, 741, 0);
        push(0, 2, -1175, -540, 0);
        push(0, 3, 720, -1609, 0);
      end
    end
    idle(5);
    chk("pulse_overrun_end", ovr[0], 0);

    // Abort mid gate 1, then a clean line from phase 0
    sv_len = 8'd8;
    push(0, 0, 12700, 0, 0);
    for (int n = 0; n < 12; n++) step(1'b1, (n % 8 == 0) ? 100 : 0);
    idle(6);
    chk("abort_valid", vld[0], 0);
    for (int g = 0; g < 4; g++) push(0, g, 12700, 0, 0);
    for (int n = 0; n < 32; n++) step(1'b1, (n % 8 == 0) ? 100 : 0);
    idle(6);

    // Asynchronous reset mid-line with a held result
    sv_len = 8'd2; rdy0 = 1'b0;
    for (int n = 0; n < 7; n++) step(1'b1, n + 1);
    chk("prereset_valid", vld[0], 1);
    chk("prereset_overrun", ovr[0], 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", vld[0], 0);
    chk("async_rst_i", oi[0], 0);
    chk("async_rst_q", oq[0], 0);
    chk("async_rst_gate", og[0], 0);
    chk("async_rst_overrun", ovr[0], 0);
    sv_len = 8'd8; rdy0 = 1'b1; line_en = 1'b1; adc = 14'd100;
    @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < 4; g++) push(0, g, 12700, 0, 0);
    for (int n = 0; n < 32; n++) step(1'b1, (n % 8 == 0) ? 100 : 0);
    idle(6);

    // SV_LEN=0: no results at all
    gate_delay = 16'd3; sv_len = 8'd0; seen = 0;
    for (int n = 0; n < 40; n++) begin
      step(1'b1, 500);
      if (vld[0]) seen++;
    end
    idle(4);
    chk("svlen0_valid_cycles", seen, 0);

    // Single gate of one sample, no wrap afterwards
    sel = 2; gate_delay = 16'd0; sv_len = 8'd1;
    push(2, 0, 6985, 0, 0);
    for (int n = 0; n < 20; n++) step(1'b1, (n == 0) ? 55 : 7);
    idle(4);
    gate_delay = 16'd8;
    push(2, 0, -2540, 0, 0);
    for (int n = 0; n < 20; n++) step(1'b1, (n == 8) ? -20 : 3);
    idle(4);

    // Saturation in a 22-bit accumulator, cleared for the next gate
    sel = 1; gate_delay = 16'd0; sv_len = 8'd8;
    push(1, 0, 2097151, 0, 1);
    push(1, 1, 0, 0, 0);
    for (int n = 0; n < 16; n++)
      step(1'b1, (n < 8 && (n == 0 || n == 1 || n == 7)) ? 8191 : 0);
    idle(6);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
